// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the instruction/data memory port arbiter.
//   arb_state_e : transaction FSM states (IDLE, ADDR, RESP, DONE)
//   OWN_I/OWN_D : encoding of the registered bus-owner bit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } arb_state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
// Saturating count of consecutive data-port grants taken while a fetch
// was waiting. Once it reaches STARVE_MAX the fetch port wins the next tie.
//   clk, reset : clock, asynchronous active-high reset
//   inc_i      : count one more D-over-I grant (holds at STARVE_MAX)
//   clr_i      : fetch was granted, start over (wins over inc_i)
//   sat_o      : count has reached STARVE_MAX
// ---------------------------------------------------------------------------
module arb_starve_ctr #(
   parameter int STARVE_MAX = 4,
   localparam int CW        = $clog2(STARVE_MAX + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory bus between the fetch port (I) and the
// data port (D). D wins ties unless D has already won STARVE_MAX ties in a
// row, in which case the fetch goes first. One transaction is in flight at
// a time; each requester gets a one-cycle registered ack when it completes.
//   clk, reset           : clock, asynchronous active-high reset
//   i_req/i_addr         : fetch request (always a full-word read)
//   i_ack/i_rdata        : fetch done pulse, registered fetch data
//   d_req/d_we/d_addr/
//   d_wdata/d_be         : data request (load or store)
//   d_ack/d_rdata        : data done pulse, registered load data
//   bus_valid/we/addr/
//   wdata/be             : registered bus request, held until bus_ready
//   bus_ready            : slave accepted the request
//   bus_rvalid/bus_rdata : read response
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ack,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,
   output logic            bus_valid,
   output logic            bus_we,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   output logic [DW/8-1:0] bus_be,
   input  logic            bus_ready,
   input  logic            bus_rvalid,
   input  logic [DW-1:0]   bus_rdata
);

   arb_state_e        state_q;
   logic              owner_q;
   logic              bus_valid_q;
   logic              bus_we_q;
   logic [AW-1:0]     bus_addr_q;
   logic [DW-1:0]     bus_wdata_q;
   logic [DW/8-1:0]   bus_be_q;
   logic              i_ack_q;
   logic              d_ack_q;
   logic [DW-1:0]     i_rdata_q;
   logic [DW-1:0]     d_rdata_q;

   logic              starve_sat;
   logic              grant_i;
   logic              grant_d;

   // D wins a tie unless the fetch has been passed over STARVE_MAX times.
   assign grant_d = (state_q == IDLE) && d_req && !(i_req && starve_sat);
   assign grant_i = (state_q == IDLE) && i_req && !grant_d;

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc_i (grant_d && i_req),
      .clr_i (grant_i),
      .sat_o (starve_sat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_I;
         bus_valid_q <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         // Acks are single-cycle: only the transition into DONE raises one.
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  owner_q     <= OWN_D;
                  bus_valid_q <= 1'b1;
                  bus_we_q    <= d_we;
                  bus_addr_q  <= d_addr;
                  bus_wdata_q <= d_wdata;
                  bus_be_q    <= d_we ? d_be : '1;
                  state_q     <= ADDR;
               end else if (grant_i) begin
                  owner_q     <= OWN_I;
                  bus_valid_q <= 1'b1;
                  bus_we_q    <= 1'b0;
                  bus_addr_q  <= i_addr;
                  bus_wdata_q <= '0;
                  bus_be_q    <= '1;
                  state_q     <= ADDR;
               end
            end
            ADDR: begin
               if (bus_ready) begin
                  bus_valid_q <= 1'b0;
                  if (bus_we_q) begin
                     i_ack_q <= (owner_q == OWN_I);
                     d_ack_q <= (owner_q == OWN_D);
                     state_q <= DONE;
                  end else begin
                     state_q <= RESP;
                  end
               end
            end
            RESP: begin
               if (bus_rvalid) begin
                  if (owner_q == OWN_D) begin
                     d_rdata_q <= bus_rdata;
                  end else begin
                     i_rdata_q <= bus_rdata;
                  end
                  i_ack_q <= (owner_q == OWN_I);
                  d_ack_q <= (owner_q == OWN_D);
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus_valid = bus_valid_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_be    = bus_be_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized run against a
// transaction-level model (memory array + grant policy + ack timing).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ack;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [BW-1:0] d_be;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          bus_valid;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [BW-1:0] bus_be;
   logic          bus_ready;
   logic          bus_rvalid;
   logic [DW-1:0] bus_rdata;

   int vectors     = 0;
   int miscompares = 0;

   mem_port_arbiter #(
      .AW         (AW),
      .DW         (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_ack      (i_ack),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_be       (d_be),
      .d_ack      (d_ack),
      .d_rdata    (d_rdata),
      .bus_valid  (bus_valid),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_be     (bus_be),
      .bus_ready  (bus_ready),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   always #5 clk = ~clk;

   // Memory contents seen by the bench's bus slave, keyed by word address.
   logic [31:0] mem [int unsigned];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      int unsigned k = a >> 2;
      if (mem.exists(k)) return mem[k];
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] be);
      logic [31:0] w = mem_rd(a);
      int unsigned k = a >> 2;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      mem[k] = w;
   endfunction

   function automatic logic [31:0] rnd_addr();
      return 32'h1000 + (32'($urandom_range(0, 15)) << 2);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      i_req      = 1'b0;
      i_addr     = '0;
      d_req      = 1'b0;
      d_we       = 1'b0;
      d_addr     = '0;
      d_wdata    = '0;
      d_be       = '0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({bus_valid, bus_we, bus_addr, bus_wdata, bus_be} !== '0) begin
         miscompares++;
         $display("FAIL reset_bus: got v=%b we=%b a=%h wd=%h be=%h, expected all 0",
                  bus_valid, bus_we, bus_addr, bus_wdata, bus_be);
      end
      vectors++;
      if ({i_ack, d_ack} !== 2'b00 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_resp: got acks=%b%b i_rdata=%h d_rdata=%h, expected 0",
                  i_ack, d_ack, i_rdata, d_rdata);
      end
   endtask

   task automatic test_single_fetch();
      do_reset();
      i_req  = 1'b1;
      i_addr = 32'h100;
      step();
      vectors++;
      if (bus_valid !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0 || bus_be !== 4'hF) begin
         miscompares++;
         $display("FAIL fetch_bus: got v=%b a=%h we=%b be=%h, expected 1/00000100/0/f",
                  bus_valid, bus_addr, bus_we, bus_be);
      end
      bus_ready = 1'b1;
      step();
      bus_ready  = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hDEADBEEF;
      vectors++;
      if (bus_valid !== 1'b0 || i_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL fetch_resp: got v=%b i_ack=%b, expected 0/0", bus_valid, i_ack);
      end
      step();
      bus_rvalid = 1'b0;
      vectors++;
      if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL fetch_ack: got i_ack=%b d_ack=%b i_rdata=%h, expected 1/0/deadbeef",
                  i_ack, d_ack, i_rdata);
      end
      i_req = 1'b0;
      step();
      vectors++;
      if (i_ack !== 1'b0 || d_ack !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL fetch_after: got i_ack=%b d_ack=%b i_rdata=%h, expected 0/0/deadbeef",
                  i_ack, d_ack, i_rdata);
      end
   endtask

   task automatic test_store_wait();
      do_reset();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h2004;
      d_wdata = 32'h12345678;
      d_be    = 4'h3;
      step();
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (bus_valid !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h2004 ||
             bus_wdata !== 32'h12345678 || bus_be !== 4'h3 || d_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL store_hold[%0d]: got v=%b we=%b a=%h wd=%h be=%h ack=%b, expected 1/1/2004/12345678/3/0",
                     c, bus_valid, bus_we, bus_addr, bus_wdata, bus_be, d_ack);
         end
         if (c == 1) d_addr = 32'hFFFF0000;
         if (c == 2) bus_ready = 1'b1;
         step();
      end
      bus_ready = 1'b0;
      vectors++;
      if (d_ack !== 1'b1 || i_ack !== 1'b0 || bus_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL store_ack: got d_ack=%b i_ack=%b v=%b, expected 1/0/0", d_ack, i_ack, bus_valid);
      end
      d_req = 1'b0;
      step();
      vectors++;
      if (d_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL store_ack_pulse: got d_ack=%b, expected 0", d_ack);
      end
   endtask

   task automatic test_starve();
      logic [9:0] order;
      int         got;
      logic       exp_d;
      order = 10'b1111011110;  // D,D,D,D,I,D,D,D,D,I (1 = D), first grant is MSB
      got   = 0;
      do_reset();
      i_req      = 1'b1;
      i_addr     = 32'h100;
      d_req      = 1'b1;
      d_we       = 1'b0;
      d_addr     = 32'h200;
      bus_ready  = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h77;
      for (int c = 0; c < 200 && got < 10; c++) begin
         step();
         if (bus_valid === 1'b1) begin
            exp_d = order[9 - got];
            vectors++;
            if (bus_addr !== (exp_d ? 32'h200 : 32'h100)) begin
               miscompares++;
               $display("FAIL starve_grant[%0d]: got addr %h, expected %h", got, bus_addr,
                        exp_d ? 32'h200 : 32'h100);
            end
            got++;
         end
      end
      vectors++;
      if (got != 10) begin
         miscompares++;
         $display("FAIL starve_timeout: got %0d grants, expected 10", got);
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h300;
      step();
      bus_ready = 1'b1;
      step();
      bus_ready = 1'b0;
      d_req     = 1'b0;
      reset     = 1'b1;
      step();
      reset      = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hBAD0BAD0;
      vectors++;
      if ({bus_valid, bus_we, bus_addr, bus_wdata, bus_be, i_ack, d_ack, i_rdata, d_rdata} !== '0) begin
         miscompares++;
         $display("FAIL midrd_reset: got v=%b acks=%b%b d_rdata=%h, expected all 0",
                  bus_valid, i_ack, d_ack, d_rdata);
      end
      step();
      bus_rvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         vectors++;
         if (i_ack !== 1'b0 || d_ack !== 1'b0 || d_rdata !== 32'h0 || bus_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrd_late[%0d]: got acks=%b%b d_rdata=%h v=%b, expected 0",
                     c, i_ack, d_ack, d_rdata, bus_valid);
         end
         step();
      end
      i_req  = 1'b1;
      i_addr = 32'h400;
      step();
      vectors++;
      if (bus_valid !== 1'b1 || bus_addr !== 32'h400) begin
         miscompares++;
         $display("FAIL midrd_next_bus: got v=%b a=%h, expected 1/400", bus_valid, bus_addr);
      end
      bus_ready = 1'b1;
      step();
      bus_ready  = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h0BADF00D;
      step();
      bus_rvalid = 1'b0;
      i_req      = 1'b0;
      vectors++;
      if (i_ack !== 1'b1 || i_rdata !== 32'h0BADF00D) begin
         miscompares++;
         $display("FAIL midrd_next_ack: got i_ack=%b i_rdata=%h, expected 1/0badf00d", i_ack, i_rdata);
      end
   endtask

   task automatic test_spurious();
      do_reset();
      bus_ready  = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h11111111;
      step();
      step();
      vectors++;
      if (bus_valid !== 1'b0 || {i_ack, d_ack} !== 2'b00 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL spur_idle: got v=%b acks=%b%b i_rdata=%h d_rdata=%h, expected 0",
                  bus_valid, i_ack, d_ack, i_rdata, d_rdata);
      end
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      d_req      = 1'b1;
      d_we       = 1'b0;
      d_addr     = 32'h500;
      step();
      bus_ready = 1'b1;
      step();
      bus_ready  = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hCAFEF00D;
      step();
      vectors++;
      if (d_ack !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL spur_load: got d_ack=%b d_rdata=%h, expected 1/cafef00d", d_ack, d_rdata);
      end
      d_req      = 1'b0;
      bus_ready  = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h22222222;
      for (int c = 0; c < 2; c++) begin
         step();
         vectors++;
         if (d_rdata !== 32'hCAFEF00D || {i_ack, d_ack} !== 2'b00 || bus_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_done[%0d]: got d_rdata=%h acks=%b%b v=%b, expected cafef00d/00/0",
                     c, d_rdata, i_ack, d_ack, bus_valid);
         end
      end
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h600;
      step();
      bus_ready = 1'b1;
      step();
      bus_ready  = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hA5A5A5A5;
      step();
      bus_rvalid = 1'b0;
      vectors++;
      if (d_ack !== 1'b1 || d_rdata !== 32'hA5A5A5A5) begin
         miscompares++;
         $display("FAIL b2b_first: got d_ack=%b d_rdata=%h, expected 1/a5a5a5a5", d_ack, d_rdata);
      end
      d_addr = 32'h604;
      step();
      step();
      vectors++;
      if (bus_valid !== 1'b1 || bus_addr !== 32'h604 || d_rdata !== 32'hA5A5A5A5) begin
         miscompares++;
         $display("FAIL b2b_second_bus: got v=%b a=%h d_rdata=%h, expected 1/604/a5a5a5a5",
                  bus_valid, bus_addr, d_rdata);
      end
      bus_ready = 1'b1;
      step();
      bus_ready = 1'b0;
      bus_rdata = 32'h5A5A5A5A;
      step();
      vectors++;
      if (d_ack !== 1'b0 || d_rdata !== 32'hA5A5A5A5) begin
         miscompares++;
         $display("FAIL b2b_hold: got d_ack=%b d_rdata=%h, expected 0/a5a5a5a5", d_ack, d_rdata);
      end
      bus_rvalid = 1'b1;
      step();
      bus_rvalid = 1'b0;
      d_req      = 1'b0;
      vectors++;
      if (d_ack !== 1'b1 || d_rdata !== 32'h5A5A5A5A) begin
         miscompares++;
         $display("FAIL b2b_second: got d_ack=%b d_rdata=%h, expected 1/5a5a5a5a", d_ack, d_rdata);
      end
   endtask

   task automatic test_random();
      int          ph;        // transaction phase: 0 free, 1 addr, 2 resp, 3 done
      int          dwins;     // consecutive D wins while I was waiting
      int          txn_i;
      int          txn_d;
      logic        own;
      logic        tx_we;
      logic [31:0] tx_addr;
      logic [31:0] tx_wdata;
      logic [3:0]  tx_be;
      logic [31:0] exp_ir;
      logic [31:0] exp_dr;
      logic        drv_i, drv_d, drv_rdy, drv_rv;
      logic        i_acked, d_acked;
      ph = 0; dwins = 0; txn_i = 0; txn_d = 0;
      own = 1'b0; tx_we = 1'b0; tx_addr = '0; tx_wdata = '0; tx_be = '0;
      exp_ir = '0; exp_dr = '0; i_acked = 1'b0; d_acked = 1'b0;
      mem.delete();
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         drv_i   = i_req;
         drv_d   = d_req;
         drv_rdy = bus_ready;
         drv_rv  = bus_rvalid;
         step();
         case (ph)
            0: if (drv_i || drv_d) begin
               if (drv_d && !(drv_i && dwins == SMAX)) begin
                  own = 1'b1; tx_we = d_we; tx_addr = d_addr; tx_wdata = d_wdata;
                  tx_be = d_we ? d_be : 4'hF;
                  if (drv_i && dwins < SMAX) dwins++;
                  txn_d++;
               end else begin
                  own = 1'b0; tx_we = 1'b0; tx_addr = i_addr; tx_be = 4'hF;
                  dwins = 0;
                  txn_i++;
               end
               ph = 1;
            end
            1: if (drv_rdy) begin
               if (tx_we) begin
                  mem_wr(tx_addr, tx_wdata, tx_be);
                  ph = 3;
               end else begin
                  ph = 2;
               end
            end
            2: if (drv_rv) begin
               if (own) exp_dr = mem_rd(tx_addr);
               else     exp_ir = mem_rd(tx_addr);
               ph = 3;
            end
            default: ph = 0;
         endcase
         vectors++;
         if (bus_valid !== (ph == 1)) begin
            miscompares++;
            $display("FAIL rnd_valid@%0d: got %b, expected %b", cyc, bus_valid, ph == 1);
         end
         if (ph == 1) begin
            vectors++;
            if (bus_we !== tx_we || bus_addr !== tx_addr || bus_be !== tx_be ||
                (tx_we && bus_wdata !== tx_wdata)) begin
               miscompares++;
               $display("FAIL rnd_bus@%0d: got we=%b a=%h wd=%h be=%h, expected %b/%h/%h/%h",
                        cyc, bus_we, bus_addr, bus_wdata, bus_be, tx_we, tx_addr, tx_wdata, tx_be);
            end
         end
         vectors++;
         if ({i_ack, d_ack} !== {(ph == 3) && !own, (ph == 3) && own}) begin
            miscompares++;
            $display("FAIL rnd_ack@%0d: got i=%b d=%b, expected i=%b d=%b", cyc, i_ack, d_ack,
                     (ph == 3) && !own, (ph == 3) && own);
         end
         vectors++;
         if (i_rdata !== exp_ir || d_rdata !== exp_dr) begin
            miscompares++;
            $display("FAIL rnd_rdata@%0d: got i=%h d=%h, expected i=%h d=%h", cyc, i_rdata, d_rdata,
                     exp_ir, exp_dr);
         end
         // bus slave: random wait states plus spurious handshakes outside their phase
         bus_ready = (ph == 1) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
         if (ph == 2 && $urandom_range(0, 2) != 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = mem_rd(bus_addr);
         end else begin
            bus_rvalid = (ph != 2) && ($urandom_range(0, 4) == 0);
            bus_rdata  = $urandom;
         end
         // requesters: act in the cycle after an ack, otherwise raise at random
         if (i_acked) begin
            i_acked = 1'b0;
            i_req   = 1'($urandom_range(0, 1));
            if (i_req) i_addr = rnd_addr();
         end else if (!i_req && $urandom_range(0, 3) == 0) begin
            i_req  = 1'b1;
            i_addr = rnd_addr();
         end
         if (d_acked || (!d_req && $urandom_range(0, 3) == 0)) begin
            d_req   = d_acked ? 1'($urandom_range(0, 1)) : 1'b1;
            d_acked = 1'b0;
            if (d_req) begin
               d_we    = 1'($urandom_range(0, 1));
               d_addr  = rnd_addr();
               d_wdata = $urandom;
               d_be    = 4'($urandom_range(1, 15));
            end
         end
         if (ph == 3) begin
            if (own) d_acked = 1'b1;
            else     i_acked = 1'b1;
         end
      end
      vectors++;
      if (txn_i < 50 || txn_d < 50) begin
         miscompares++;
         $display("FAIL rnd_progress: got %0d fetches %0d data, expected at least 50 each", txn_i, txn_d);
      end
   endtask

   initial begin
      reset      = 1'b1;
      i_req      = 1'b0;
      i_addr     = '0;
      d_req      = 1'b0;
      d_we       = 1'b0;
      d_addr     = '0;
      d_wdata    = '0;
      d_be       = '0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      test_reset();
      test_single_fetch();
      test_store_wait();
      test_starve();
      test_reset_mid_read();
      test_spurious();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
